// File: rtl/risc_pkg.sv
// Shared constants and types for the fetch stage.
// Feature macro used by the fetch stage: FETCH_HALT_EN.
package risc_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [INSTR_W-1:0] NOP_WORD = 16'h0000;

  // Opcode field position within an instruction word
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  typedef enum logic [1:0] {
    PC_HOLD     = 2'd0,
    PC_INC      = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_t;

  function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register: holds, increments (wrapping modulo 2^PC_W) or
// loads a redirect target. Redirect has priority over increment.
module fetch_pc_gen
  import risc_pkg::*;
#(
  parameter int              PC_W     = risc_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            advance,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  output logic [PC_W-1:0] pc
);

  pc_sel_t         sel;
  logic [PC_W-1:0] pc_next;

  always_comb begin
    sel = PC_HOLD;
    if (load) begin
      sel = PC_REDIRECT;
    end else if (advance) begin
      sel = PC_INC;
    end
  end

  always_comb begin
    pc_next = pc;
    case (sel)
      PC_REDIRECT: pc_next = load_pc;
      // Natural truncation gives the wrap from all-ones back to zero
      PC_INC:      pc_next = pc + {{(PC_W-1){1'b0}}, 1'b1};
      default:     pc_next = pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: drives pc to instruction memory, registers the returned word
// with its address, and offers it to decode. Optional halt on zero word: FETCH_HALT_EN.
//
// Handshake: a word transfers on a rising edge where out_valid=1 and
// out_ready=1; out_valid/out_instr/out_pc never change while out_valid=1
// and out_ready=0, except that redirect_valid flushes the word unconditionally.
module instruction_fetch
  import risc_pkg::*;
#(
  parameter int                 PC_W     = risc_pkg::PC_W,
  parameter int                 INSTR_W  = risc_pkg::INSTR_W,
  parameter logic [PC_W-1:0]    RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_en,
  output logic [PC_W-1:0]    pc,
  input  logic [INSTR_W-1:0] mem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               halted,
  output logic [15:0]        fetch_count
);

  fetch_state_t state;
  fetch_state_t state_next;
  logic         capture;
  logic         consume;
  logic         halt_trigger;

  fetch_pc_gen #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (capture),
    .load    (redirect_valid),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state;
    if (redirect_valid) begin
      state_next = ST_RUN;
    end else begin
      case (state)
        ST_RUN: begin
          if (halt_trigger) begin
            state_next = ST_HALT;
          end else if (out_valid && !out_ready) begin
            state_next = ST_STALL;
          end
        end
        ST_STALL: begin
          if (out_ready) begin
            state_next = halt_trigger ? ST_HALT : ST_RUN;
          end
        end
`ifdef FETCH_HALT_EN
        ST_HALT: state_next = ST_HALT;
`endif
        default: state_next = ST_RUN;
      endcase
    end
  end

  // FSM: outputs and control strobes
  always_comb begin
`ifdef FETCH_HALT_EN
    halted       = (state == ST_HALT);
`else
    halted       = 1'b0;
`endif
    capture      = fetch_en & ~halted & (~out_valid | out_ready) & ~redirect_valid;
    consume      = out_valid & out_ready;
`ifdef FETCH_HALT_EN
    halt_trigger = capture & (mem_instr == NOP_WORD);
`else
    halt_trigger = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_pc      <= '0;
      fetch_count <= '0;
    end else if (redirect_valid) begin
      out_valid <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_instr <= mem_instr;
      out_pc    <= pc;
      if (fetch_count != 16'hFFFF) begin
        fetch_count <= fetch_count + 16'd1;
      end
    end else if (consume) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an expected-word scoreboard.
// Works with or without FETCH_HALT_EN defined.
module tb_instruction_fetch;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;
  localparam int W       = PC_W + INSTR_W;

  logic               clk;
  logic               rst_n;
  logic               fetch_en;
  logic [PC_W-1:0]    pc;
  logic [INSTR_W-1:0] mem_instr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc;
  logic               redirect_valid;
  logic [PC_W-1:0]    redirect_pc;
  logic               halted;
  logic [15:0]        fetch_count;

  logic [INSTR_W-1:0] mem [256];
  logic [W-1:0]       exp_q [$];

  int checks = 0;
  int errors = 0;

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  assign mem_instr = mem[pc];

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .pc             (pc),
    .mem_instr      (mem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halted         (halted),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [PC_W-1:0] a);
    exp_q.push_back({a, mem[a]});
  endtask

  task automatic do_redirect(input logic [PC_W-1:0] target);
    redirect_valid = 1'b1;
    redirect_pc    = target;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Monitor: every accepted word must match the head of the expected queue
  always @(negedge clk) begin
    logic [W-1:0] e;
    if (rst_n && out_valid && out_ready && !redirect_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got %h/%h expected none", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          errors++;
          $display("FAIL xfer: got %h/%h expected %h/%h", out_pc, out_instr,
                   e[W-1:INSTR_W], e[INSTR_W-1:0]);
        end
      end
    end
  end

  logic [PC_W-1:0] exp_pc_t1;
  logic [15:0]     exp_cnt;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h8000 | 16'(i);
    mem[0] = 16'h3505;
    mem[1] = 16'h1550;
    mem[2] = 16'h4502;
    mem[3] = 16'h0000;

    rst_n = 1'b0; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    #12;
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_count", 32'(fetch_count), 32'h0);
    check("rst_halted", 32'(halted), 32'h0);
    check("rst_out_instr", 32'(out_instr), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Streaming program at full throughput
    push(0); push(1); push(2); push(3);
`ifndef FETCH_HALT_EN
    push(4);
`endif
    fetch_en = 1'b1; out_ready = 1'b1;
    tick();
    check("t1_first_pc", 32'(out_pc), 32'h0);
    check("t1_first_instr", 32'(out_instr), 32'h3505);
    tick(); tick(); tick();
    check("t1_out_pc3", 32'(out_pc), 32'h3);
    check("t1_pc4", 32'(pc), 32'h4);
    check("t1_count4", 32'(fetch_count), 32'h4);
    tick();
`ifdef FETCH_HALT_EN
    exp_pc_t1 = 8'h04; exp_cnt = 16'd4;
`else
    exp_pc_t1 = 8'h05; exp_cnt = 16'd5;
`endif
    check("t1_pc_after", 32'(pc), 32'(exp_pc_t1));
    check("t1_count_after", 32'(fetch_count), 32'(exp_cnt));
`ifdef FETCH_HALT_EN
    check("t1_halted", 32'(halted), 32'h1);
    check("t1_valid_drop", 32'(out_valid), 32'h0);
`endif
    fetch_en = 1'b0;
    tick();
    check("t1_idle_valid", 32'(out_valid), 32'h0);
    check("t1_idle_pc", 32'(pc), 32'(exp_pc_t1));

    // Stall for three cycles on word 1, then release
    fetch_en = 1'b1;
    do_redirect(8'h00);
    check("t2_redir_pc", 32'(pc), 32'h0);
    check("t2_redir_halted", 32'(halted), 32'h0);
    push(0); push(1); push(2);
    tick(); tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t2_stall_instr", 32'(out_instr), 32'h1550);
      check("t2_stall_pc", 32'(pc), 32'h2);
      check("t2_stall_valid", 32'(out_valid), 32'h1);
    end
    out_ready = 1'b1;
    tick();
    check("t2_release_instr", 32'(out_instr), 32'h4502);
    check("t2_release_pc", 32'(pc), 32'h3);
    fetch_en = 1'b0;
    tick();
    check("t2_consumed_valid", 32'(out_valid), 32'h0);
    check("t2_consumed_pc", 32'(pc), 32'h3);

    // Redirect during stall discards the held word
    fetch_en = 1'b1;
    do_redirect(8'h00);
    push(0);
    tick(); tick();
    out_ready = 1'b0;
    tick();
    check("t3_stall_out_pc", 32'(out_pc), 32'h1);
    redirect_valid = 1'b1; redirect_pc = 8'h00;
    tick();
    redirect_valid = 1'b0;
    check("t3_flush_valid", 32'(out_valid), 32'h0);
    check("t3_flush_pc", 32'(pc), 32'h0);
    out_ready = 1'b1;
    push(0);
    tick();
    check("t3_target_instr", 32'(out_instr), 32'h3505);
    check("t3_target_out_pc", 32'(out_pc), 32'h0);
    fetch_en = 1'b0;
    tick();

    // Wrap from FE through 01
    fetch_en = 1'b1;
    do_redirect(8'hFE);
    check("t4_pc_fe", 32'(pc), 32'hFE);
    push(8'hFE); push(8'hFF); push(8'h00); push(8'h01);
    tick(); tick();
    check("t4_out_pc_ff", 32'(out_pc), 32'hFF);
    check("t4_pc_wrap", 32'(pc), 32'h00);
    tick(); tick();
    fetch_en = 1'b0;
    tick();
    check("t4_pc_end", 32'(pc), 32'h2);
    check("t4_count", 32'(fetch_count), 32'(exp_cnt + 16'd10));

    // Asynchronous reset in the middle of a stall
    fetch_en = 1'b1;
    do_redirect(8'h00);
    out_ready = 1'b0;
    tick(); tick();
    check("t5_stalled", 32'(out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_pc", 32'(pc), 32'h0);
    check("t5_rst_valid", 32'(out_valid), 32'h0);
    check("t5_rst_count", 32'(fetch_count), 32'h0);
    check("t5_rst_halted", 32'(halted), 32'h0);
    fetch_en = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    check("queue_empty", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage and sole reader of the 256x16 instruction memory. It drives the memory's pc address and samples the instruction word that memory returns combinationally in the same cycle. It registers each fetched word with its PC and hands it to decode over a valid/ready handshake. It supports stall, redirect (branch/jump) with flush, PC wrap-around, and optional halt on an all-zero word.

Parameters:
PC_W, 8, address width of instruction memory / PC
INSTR_W, 16, instruction word width
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
fetch_en  in  1  level enable; 0 freezes fetch (pc held, no new capture)
pc  out  PC_W  address to instruction memory
mem_instr  in  INSTR_W  word returned by memory for current pc (combinational)
out_valid  out  1  out_instr/out_pc hold a valid fetched word
out_ready  in  1  decode accepts word this cycle when out_valid=1
out_instr  out  INSTR_W  registered instruction
out_pc  out  PC_W  address the instruction was fetched from
redirect_valid  in  1  branch/jump taken; overrides everything except reset
redirect_pc  in  PC_W  target address
halted  out  1  fetch halted (only meaningful with FETCH_HALT_EN; else tied 0)
fetch_count  out  16  number of words captured since reset, saturating at 16'hFFFF

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, out_valid=0, out_instr=0, out_pc=0, halted=0, fetch_count=0, state=RUN.
- States: RUN, STALL, HALT (HALT exists only with FETCH_HALT_EN).
- capture = fetch_en & ~halted & (~out_valid | out_ready) & ~redirect_valid.
- On a capture edge:
  - out_instr<=mem_instr, out_pc<=pc, out_valid<=1.
  - pc<=pc+1 (mod 2^PC_W; 8'hFF wraps to 8'h00).
  - fetch_count increments, saturating.
- Latency: one clock from pc presented to the word appearing on out_instr with out_valid=1. Sustained throughput is 1 word/cycle while out_ready=1.
- Stall (RUN->STALL): out_valid=1 & out_ready=0. pc, out_instr, out_pc and out_valid hold; no capture. STALL->RUN on the first cycle with out_ready=1; that cycle also captures the next word, giving back-to-back transfer.
- out_valid=1 & out_ready=1 & fetch_en=0: word is consumed, out_valid<=0, pc holds.
- Redirect (any state): next edge pc<=redirect_pc, out_valid<=0 (the held or in-flight word is flushed even if out_ready=1), state<=RUN, halted<=0. The first word from the target is captured the following cycle.
- Redirect during stall: redirect wins and the stalled word is discarded.
- Redirect with redirect_pc equal to the current pc: still flushes.
- fetch_en=0: no state change except consumption and redirect. Redirect is still honoured.
- Reset mid-stall or mid-halt: immediate return to reset values, no partial output.
- out_instr, out_pc and fetch_count change only on capture.

Optional Feature:
FETCH_HALT_EN
- Defined: a captured word equal to 16'h0000 is still presented to decode (out_valid=1). The fetch unit then enters HALT, sets halted=1 and holds pc at the zero word's address+1 with no further captures. Exit only by redirect_valid or reset.
- Undefined: 16'h0000 is an ordinary NOP; fetch continues and wraps; halted tied 0; no HALT state.

Decomposition:
- Shared package risc_pkg: PC_W, INSTR_W, NOP_WORD=16'h0000, opcode field slice [15:12], fetch state enum {RUN, STALL, HALT}.
- One natural sub-module: fetch_pc_gen. It holds the PC register and selects among hold / pc+1 / redirect_pc, with wrap.

Test Plan:
- Memory words 0:16'h3505, 1:16'h1550, 2:16'h4502, 3:16'h0000; out_ready=1, fetch_en=1 after reset -> out_pc/out_instr = 0/3505, 1/1550, 2/4502, 3/0000 on consecutive cycles; fetch_count=4.
- With FETCH_HALT_EN, same program -> after word 3, halted=1, pc=4, out_valid drops once consumed, fetch_count stays 4. Without the macro, pc reaches 5 on the next cycle.
- out_ready=0 for 3 cycles while out_pc=1 -> out_instr stays 16'h1550 and pc stays 2. On release, 16'h4502 follows the next cycle.
- Stall at out_pc=1, then redirect_valid with redirect_pc=8'h00 -> next cycle out_valid=0, pc=0. The following cycle gives out_instr=16'h3505, out_pc=0.
- redirect_pc=8'hFE, free-running -> out_pc sequence FE, FF, 00, 01 (wrap).
- Assert rst_n=0 asynchronously mid-stall -> pc=RESET_PC, out_valid=0, fetch_count=0 before the next clock edge.
